array_div_row_seq: RTL and testbench

- Sequencer directly upstream and downstream of the array divider in the inverse datapath.
- Collects one matrix row of N 27-bit words serially and presents it in parallel as dividends, with the selected pivot word as divisor.
- Runs the divider for a fixed latency, captures the quotients and streams the normalised row back out serially.
- Zero pivots are flagged and the row is dropped.

---
 rtl/array_div_row_seq.sv | 200 ++++++++++++++++++++
 tb/tb_array_div_row_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_div_row_seq.sv
// Row sequencer around the array divider: serial row in, parallel divide by the pivot word,
// serial normalised row out. A zero or out-of-range pivot raises pivot_err and drops the row.
module array_div_row_seq #(
  parameter int N       = 6,
  parameter int DIV_LAT = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [$clog2(N)-1:0] pivot_idx,
  input  logic                 in_valid,
  input  logic [26:0]          in_data,
  output logic                 in_ready,
  output logic                 div_rst,
  output logic                 div_en,
  output logic [N*27-1:0]      div_dividends,
  output logic [26:0]          div_divisor,
  input  logic [N*27-1:0]      div_quotients,
  output logic                 out_valid,
  output logic [26:0]          out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 pivot_err,
  output logic                 busy
);
  localparam int W  = 27;
  localparam int CW = $clog2(N);
  localparam int LW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_CHECK = 3'd1,
    S_CLR   = 3'd2,
    S_RUN   = 3'd3,
    S_CAP   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [CW-1:0]  cnt_r, cnt_nxt_s;
  logic [CW-1:0]  piv_r, piv_nxt_s, piv_eff_s;
  logic [CW-1:0]  ocnt_r, ocnt_nxt_s;
  logic [LW-1:0]  lat_cnt_r, lat_nxt_s;
  logic [W-1:0]   row_r [N];
  logic [W-1:0]   row_nxt_s [N];
  logic [W-1:0]   res_r [N];
  logic [W-1:0]   res_nxt_s [N];
  logic [N*W-1:0] dvd_r, dvd_nxt_s;
  logic [W-1:0]   dvs_r, dvs_nxt_s;
  logic           perr_nxt_s;

  logic           in_ready_r, div_rst_r, div_en_r, out_valid_r, out_last_r, pivot_err_r, busy_r;
  logic [W-1:0]   out_data_r;

  assign in_ready      = in_ready_r;
  assign div_rst       = div_rst_r;
  assign div_en        = div_en_r;
  assign div_dividends = dvd_r;
  assign div_divisor   = dvs_r;
  assign out_valid     = out_valid_r;
  assign out_data      = out_data_r;
  assign out_last      = out_last_r;
  assign pivot_err     = pivot_err_r;
  assign busy          = busy_r;

  // Next-state decode plus next values of counters, row/result buffers and divider operands
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    piv_nxt_s   = piv_r;
    piv_eff_s   = piv_r;
    ocnt_nxt_s  = ocnt_r;
    lat_nxt_s   = lat_cnt_r;
    row_nxt_s   = row_r;
    res_nxt_s   = res_r;
    dvd_nxt_s   = dvd_r;
    dvs_nxt_s   = dvs_r;
    perr_nxt_s  = 1'b0;
    case (state_r)
      S_LOAD: begin
        if (in_valid) begin
          row_nxt_s[cnt_r] = in_data;
          if (cnt_r == CW'(0)) begin
            piv_eff_s = pivot_idx;
          end else begin
            piv_eff_s = piv_r;
          end
          piv_nxt_s = piv_eff_s;
          if (cnt_r == CW'(N - 1)) begin
            cnt_nxt_s   = CW'(0);
            state_nxt_s = S_CHECK;
            // Pivot test looks ahead at the row including this final word so pivot_err is a flop
            if (int'(piv_eff_s) >= N) begin
              perr_nxt_s = 1'b1;
            end else begin
              perr_nxt_s = (row_nxt_s[piv_eff_s] == W'(0));
            end
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      S_CHECK: begin
        if (pivot_err_r) begin
          state_nxt_s = S_LOAD;
        end else begin
          state_nxt_s = S_CLR;
          for (int i = 0; i < N; i++) begin
            dvd_nxt_s[i*W +: W] = row_r[i];
          end
          dvs_nxt_s = row_r[piv_r];
        end
      end
      S_CLR: begin
        state_nxt_s = S_RUN;
        lat_nxt_s   = LW'(0);
      end
      S_RUN: begin
        if (lat_cnt_r == LW'(DIV_LAT - 1)) begin
          state_nxt_s = S_CAP;
          lat_nxt_s   = LW'(0);
        end else begin
          lat_nxt_s = lat_cnt_r + LW'(1);
        end
      end
      S_CAP: begin
        for (int i = 0; i < N; i++) begin
          res_nxt_s[i] = div_quotients[i*W +: W];
        end
        ocnt_nxt_s  = CW'(0);
        state_nxt_s = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (ocnt_r == CW'(N - 1)) begin
            ocnt_nxt_s  = CW'(0);
            state_nxt_s = S_LOAD;
          end else begin
            ocnt_nxt_s = ocnt_r + CW'(1);
          end
        end else begin
          ocnt_nxt_s = ocnt_r;
        end
      end
      default: begin
        state_nxt_s = S_LOAD;
        cnt_nxt_s   = CW'(0);
        ocnt_nxt_s  = CW'(0);
        lat_nxt_s   = LW'(0);
      end
    endcase
  end

  // State, datapath registers and outputs; outputs are decoded from the next state so they are flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_LOAD;
      cnt_r       <= CW'(0);
      piv_r       <= CW'(0);
      ocnt_r      <= CW'(0);
      lat_cnt_r   <= LW'(0);
      for (int i = 0; i < N; i++) begin
        row_r[i] <= W'(0);
        res_r[i] <= W'(0);
      end
      dvd_r       <= {(N*W){1'b0}};
      dvs_r       <= W'(0);
      in_ready_r  <= 1'b1;
      div_rst_r   <= 1'b0;
      div_en_r    <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= W'(0);
      pivot_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      piv_r       <= piv_nxt_s;
      ocnt_r      <= ocnt_nxt_s;
      lat_cnt_r   <= lat_nxt_s;
      row_r       <= row_nxt_s;
      res_r       <= res_nxt_s;
      dvd_r       <= dvd_nxt_s;
      dvs_r       <= dvs_nxt_s;
      in_ready_r  <= (state_nxt_s == S_LOAD);
      div_rst_r   <= (state_nxt_s == S_CLR);
      div_en_r    <= (state_nxt_s == S_RUN);
      out_valid_r <= (state_nxt_s == S_DRAIN);
      out_last_r  <= (state_nxt_s == S_DRAIN) && (ocnt_nxt_s == CW'(N - 1));
      pivot_err_r <= perr_nxt_s;
      busy_r      <= !((state_nxt_s == S_LOAD) && (cnt_nxt_s == CW'(0)));
      if (state_nxt_s == S_DRAIN) begin
        out_data_r <= res_nxt_s[ocnt_nxt_s];
      end
    end
  end

endmodule

// File: tb/tb_array_div_row_seq.sv
// Randomised self-checking bench for array_div_row_seq with a latency-accurate divider stand-in
// and a row-level reference model (each word divided by the row's pivot word).
module tb_array_div_row_seq;
  localparam int N       = 6;
  localparam int DIV_LAT = 4;
  localparam int W       = 27;
  typedef logic [W-1:0] row_t [N];

  logic           clk = 1'b0;
  logic           rst_n;
  logic [2:0]     pivot_idx;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic           div_rst;
  logic           div_en;
  logic [N*W-1:0] div_dividends;
  logic [W-1:0]   div_divisor;
  logic [N*W-1:0] div_quotients;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready = 1'b1;
  logic           pivot_err;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  array_div_row_seq #(.N(N), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .pivot_idx(pivot_idx), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .div_rst(div_rst), .div_en(div_en), .div_dividends(div_dividends),
    .div_divisor(div_divisor), .div_quotients(div_quotients), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready), .pivot_err(pivot_err),
    .busy(busy)
  );

  // Divider stand-in: quotients are only valid after exactly DIV_LAT enabled cycles since div_rst
  int div_cnt = 0;
  always @(posedge clk) begin
    if (div_rst) div_cnt <= 0;
    else if (div_en) div_cnt <= div_cnt + 1;
  end
  always_comb begin
    div_quotients = '1;
    for (int i = 0; i < N; i++)
      if (div_cnt == DIV_LAT && div_divisor != 0)
        div_quotients[i*W +: W] = div_dividends[i*W +: W] / div_divisor;
  end

  // Monitor: records handshakes and event counts at the active edge
  int cyc = 0, last_in_cyc = 0, rise_cyc = 0;
  int en_cyc = 0, rst_cyc = 0, perr_cyc = 0, ov_cyc = 0, stall_cyc = 0;
  int stall_viol = 0, overlap_viol = 0;
  logic ov_prev = 1'b0, stall_prev = 1'b0, last_prev = 1'b0;
  logic [W-1:0] data_prev = '0;
  logic [W-1:0] got_data [$];
  logic         got_last [$];
  logic [W-1:0] en_divs [$];
  always @(posedge clk) begin
    if (rst_n) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) last_in_cyc <= cyc;
      if (out_valid && !ov_prev) rise_cyc <= cyc - 1;
      if (stall_prev && (!out_valid || out_data !== data_prev || out_last !== last_prev))
        stall_viol <= stall_viol + 1;
      if (out_valid && !out_ready) stall_cyc <= stall_cyc + 1;
      if (out_valid && in_ready) overlap_viol <= overlap_viol + 1;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (div_en) begin
        en_cyc <= en_cyc + 1;
        en_divs.push_back(div_divisor);
      end
      if (div_rst) rst_cyc <= rst_cyc + 1;
      if (pivot_err) perr_cyc <= perr_cyc + 1;
      if (out_valid) ov_cyc <= ov_cyc + 1;
      stall_prev <= out_valid && !out_ready;
      ov_prev    <= out_valid;
      data_prev  <= out_data;
      last_prev  <= out_last;
    end else begin
      stall_prev <= 1'b0;
      ov_prev    <= 1'b0;
    end
  end

  // Downstream ready: 0 = always ready, 1 = random, 2 = random with one 5-cycle stall mid-row
  int rdy_mode = 0, bp_base = 0, hold = 0;
  bit held = 1'b0;
  always @(negedge clk) begin
    if (rdy_mode == 0) begin
      out_ready <= 1'b1; held <= 1'b0; hold <= 0;
    end else if (rdy_mode == 2 && !held && out_valid && (got_data.size() - bp_base) == 3) begin
      out_ready <= 1'b0; held <= 1'b1; hold <= 4;
    end else if (hold > 0) begin
      out_ready <= 1'b0; hold <= hold - 1;
    end else begin
      out_ready <= 1'($urandom_range(1, 0));
    end
  end

  logic [W-1:0] exp_data [$];
  logic         exp_last [$];

  task automatic expect_row(input row_t w, input int piv);
    if (piv < N) begin
      if (w[piv] != 0)
        for (int i = 0; i < N; i++) begin
          exp_data.push_back(w[i] / w[piv]);
          exp_last.push_back(i == N - 1);
        end
    end
  endtask

  task automatic rand_row(output row_t w, input int piv);
    for (int i = 0; i < N; i++) w[i] = W'($urandom);
    w[piv] = W'($urandom_range(64, 1));
  endtask

  task automatic send_row(input row_t w, input int piv, input int nw, input int gap_pct);
    int t;
    for (int i = 0; i < nw; i++) begin
      while (int'($urandom_range(99, 0)) < gap_pct) begin
        in_valid = 1'b0; pivot_idx = 3'($urandom); @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = w[i];
      pivot_idx = (i == 0) ? 3'(piv) : 3'($urandom);
      t = 0;
      while (!in_ready && t < 400) begin @(negedge clk); t++; end
      if (!in_ready) begin
        n_tests++; n_fail++;
        $display("FAIL in_accept word %0d: in_ready=%b, required 1 within 400 cycles", i, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target);
    int t = 0;
    while (got_data.size() < target && t < 2000) begin @(negedge clk); t++; end
    if (got_data.size() < target) begin
      n_tests++; n_fail++;
      $display("FAIL out_timeout: got %0d words, required %0d", got_data.size(), target);
    end
  endtask

  task automatic compare_out(input string name, input int base);
    for (int i = 0; i < exp_data.size(); i++) begin
      n_tests++;
      if (got_data[base+i] !== exp_data[i] || got_last[base+i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL %s word %0d: got %0d last %b, required %0d last %b", name, i,
                 got_data[base+i], got_last[base+i], exp_data[i], exp_last[i]);
      end
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (got_data.size() !== base + exp_data.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d words, required %0d", name, got_data.size() - base, exp_data.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; pivot_idx = '0; rdy_mode = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b, required 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b, required 0", out_valid); end
    n_tests++; if (div_en !== 1'b0) begin n_fail++; $display("FAIL reset div_en: got %b, required 0", div_en); end
    n_tests++; if (div_rst !== 1'b0) begin n_fail++; $display("FAIL reset div_rst: got %b, required 0", div_rst); end
    n_tests++; if (pivot_err !== 1'b0) begin n_fail++; $display("FAIL reset pivot_err: got %b, required 0", pivot_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, required 0", busy); end
    n_tests++; if (out_last !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL reset out_data/last: got %0d/%b, required 0/0", out_data, out_last); end
    n_tests++; if (div_divisor !== '0 || div_dividends !== '0) begin n_fail++; $display("FAIL reset div operands: got divisor %0d, required 0", div_divisor); end
  endtask

  task automatic test_basic();
    row_t w;
    int base, en0, rs0, d0;
    logic [W-1:0] want [N];
    w = '{27'd10, 27'd20, 27'd5, 27'd15, 27'd0, 27'd25};
    want = '{27'd2, 27'd4, 27'd1, 27'd3, 27'd0, 27'd5};
    base = got_data.size(); en0 = en_cyc; rs0 = rst_cyc; d0 = en_divs.size();
    send_row(w, 2, N, 0);
    wait_out(base + N);
    repeat (2) @(negedge clk);
    n_tests++; if (rst_cyc - rs0 !== 1) begin n_fail++; $display("FAIL basic div_rst pulses: got %0d, required 1", rst_cyc - rs0); end
    n_tests++; if (en_cyc - en0 !== DIV_LAT) begin n_fail++; $display("FAIL basic div_en cycles: got %0d, required %0d", en_cyc - en0, DIV_LAT); end
    for (int k = d0; k < en_divs.size(); k++) begin
      n_tests++; if (en_divs[k] !== 27'd5) begin n_fail++; $display("FAIL basic divisor: got %0d, required 5", en_divs[k]); end
    end
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (got_data[base+i] !== want[i] || got_last[base+i] !== (i == N - 1)) begin
        n_fail++;
        $display("FAIL basic word %0d: got %0d last %b, required %0d last %b", i, got_data[base+i], got_last[base+i], want[i], i == N - 1);
      end
    end
    n_tests++; if (rise_cyc - last_in_cyc !== DIV_LAT + 3) begin n_fail++; $display("FAIL basic latency: got %0d, required %0d", rise_cyc - last_in_cyc, DIV_LAT + 3); end
    n_tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL basic idle: busy %b in_ready %b, required 0 1", busy, in_ready); end
  endtask

  task automatic test_zero_pivot();
    row_t w;
    int p0, e0, o0, base;
    w = '{27'd7, 27'd9, 27'd3, 27'd1, 27'd0, 27'd8};
    p0 = perr_cyc; e0 = en_cyc; o0 = ov_cyc;
    send_row(w, 4, N, 0);
    n_tests++; if (pivot_err !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL zero check cycle: pivot_err %b in_ready %b, required 1 0", pivot_err, in_ready); end
    @(negedge clk);
    n_tests++; if (pivot_err !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL zero return: pivot_err %b in_ready %b, required 0 1", pivot_err, in_ready); end
    repeat (5) @(negedge clk);
    n_tests++; if (perr_cyc - p0 !== 1) begin n_fail++; $display("FAIL zero pulse width: got %0d, required 1", perr_cyc - p0); end
    n_tests++; if (en_cyc - e0 !== 0 || ov_cyc - o0 !== 0) begin n_fail++; $display("FAIL zero activity: div_en %0d out_valid %0d cycles, required 0 0", en_cyc - e0, ov_cyc - o0); end
    // Out-of-range pivot index behaves like a zero pivot
    rand_row(w, 1);
    p0 = perr_cyc; o0 = ov_cyc;
    send_row(w, 7, N, 0);
    repeat (6) @(negedge clk);
    n_tests++; if (perr_cyc - p0 !== 1 || ov_cyc - o0 !== 0) begin n_fail++; $display("FAIL range pivot: pivot_err %0d out_valid %0d cycles, required 1 0", perr_cyc - p0, ov_cyc - o0); end
    // Only the MSB set is a non-zero pivot
    rand_row(w, 1);
    w[1] = 27'h4000000;
    p0 = perr_cyc; base = got_data.size();
    exp_data.delete(); exp_last.delete();
    expect_row(w, 1);
    send_row(w, 1, N, 0);
    wait_out(base + N);
    compare_out("msb_pivot", base);
    n_tests++; if (perr_cyc - p0 !== 0) begin n_fail++; $display("FAIL msb pivot_err: got %0d pulses, required 0", perr_cyc - p0); end
  endtask

  task automatic test_backpressure();
    row_t w;
    int piv, base, sv0, ovl0, sc0;
    piv = $urandom_range(N - 1, 0);
    rand_row(w, piv);
    exp_data.delete(); exp_last.delete();
    expect_row(w, piv);
    base = got_data.size(); sv0 = stall_viol; ovl0 = overlap_viol; sc0 = stall_cyc;
    bp_base = base; rdy_mode = 2;
    send_row(w, piv, N, 0);
    wait_out(base + N);
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp after last: in_ready %b out_valid %b, required 1 0", in_ready, out_valid); end
    rdy_mode = 0;
    compare_out("backpressure", base);
    n_tests++; if (stall_viol - sv0 !== 0) begin n_fail++; $display("FAIL bp stability: got %0d changes while stalled, required 0", stall_viol - sv0); end
    n_tests++; if (overlap_viol - ovl0 !== 0) begin n_fail++; $display("FAIL bp overlap: got %0d in_ready during drain, required 0", overlap_viol - ovl0); end
    n_tests++; if (stall_cyc - sc0 < 5) begin n_fail++; $display("FAIL bp stall cycles: got %0d, required at least 5", stall_cyc - sc0); end
  endtask

  task automatic test_gapped();
    row_t w;
    int piv, base;
    exp_data.delete(); exp_last.delete();
    base = got_data.size();
    rdy_mode = 1;
    for (int r = 0; r < 2; r++) begin
      piv = $urandom_range(N - 1, 0);
      rand_row(w, piv);
      expect_row(w, piv);
      send_row(w, piv, N, 50);
    end
    wait_out(base + 2 * N);
    rdy_mode = 0;
    compare_out("gapped", base);
  endtask

  task automatic test_reset_mid_run();
    row_t w;
    int k, t, base;
    rand_row(w, 0);
    send_row(w, 0, 3, 0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL partial busy: got %b, required 1", busy); end
    rst_n = 1'b0; #1;
    n_tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL partial reset: busy %b in_ready %b, required 0 1", busy, in_ready); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    rand_row(w, 3);
    send_row(w, 3, N, 0);
    k = 0; t = 0;
    while (k < 3 && t < 50) begin @(negedge clk); if (div_en) k++; t++; end
    n_tests++; if (k != 3) begin n_fail++; $display("FAIL midrun div_en: saw %0d enabled cycles, required 3", k); end
    base = got_data.size();
    rst_n = 1'b0; #1;
    n_tests++; if (div_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrun async drop: div_en %b out_valid %b busy %b, required 0 0 0", div_en, out_valid, busy); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrun in_ready: got %b, required 1", in_ready); end
    exp_data.delete(); exp_last.delete();
    rand_row(w, 5);
    expect_row(w, 5);
    send_row(w, 5, N, 0);
    wait_out(base + N);
    compare_out("after_reset", base);
  endtask

  task automatic test_back_to_back();
    row_t w;
    int pivs [3];
    int base, ovl0;
    pivs = '{0, 5, 3};
    exp_data.delete(); exp_last.delete();
    base = got_data.size(); ovl0 = overlap_viol;
    rdy_mode = 1;
    for (int r = 0; r < 3; r++) begin
      rand_row(w, pivs[r]);
      expect_row(w, pivs[r]);
      send_row(w, pivs[r], N, 0);
    end
    wait_out(base + 3 * N);
    rdy_mode = 0;
    compare_out("back_to_back", base);
    n_tests++; if (overlap_viol - ovl0 !== 0) begin n_fail++; $display("FAIL b2b overlap: got %0d, required 0", overlap_viol - ovl0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_pivot();
    test_backpressure();
    test_gapped();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
